// File: rtl/io_uart.sv
// -----------------------------------------------------------------------------
// io_uart -- memory-mapped 8N1 UART with a 4-entry transmit FIFO and a
// single-byte receive holding register.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (4..65535)
//   DATA_ADDR     IO address of the data register (write: TX push, read: RX byte)
//   STAT_ADDR     IO address of the status register
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_bus        CPU write data
//   o_bus        read data, 8'h00 when o_busEnable is low
//   o_busEnable  high while a read access targets DATA_ADDR or STAT_ADDR
//   i_ioSelect   IO space selected
//   i_ioAddress  IO register address
//   i_ioNOE      active-low read strobe
//   i_ioNWE      active-low write strobe
//   i_rx         asynchronous serial input, idle high
//   o_tx         serial output, idle high
//
// Status register: {3'b0, frame_err, overrun, rx_valid, tx_idle, tx_not_full}
// Status write: i_bus[2] clears overrun, i_bus[3] clears frame_err.
// -----------------------------------------------------------------------------
module io_uart #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [7:0]  DATA_ADDR    = 8'h01,
    parameter logic [7:0]  STAT_ADDR    = 8'h02
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_bus,
    output logic [7:0] o_bus,
    output logic       o_busEnable,
    input  logic       i_ioSelect,
    input  logic [7:0] i_ioAddress,
    input  logic       i_ioNOE,
    input  logic       i_ioNWE,
    input  logic       i_rx,
    output logic       o_tx
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // ------------------------------------------------------------------
    // Bus decode and access edge detection
    // ------------------------------------------------------------------
    logic rd_data, rd_stat, wr_data, wr_stat;
    logic rd_data_q, wr_data_q, wr_stat_q;
    logic rd_data_pulse, wr_data_pulse, wr_stat_pulse;

    assign rd_data = i_ioSelect & ~i_ioNOE & (i_ioAddress == DATA_ADDR);
    assign rd_stat = i_ioSelect & ~i_ioNOE & (i_ioAddress == STAT_ADDR);
    assign wr_data = i_ioSelect & ~i_ioNWE & (i_ioAddress == DATA_ADDR);
    assign wr_stat = i_ioSelect & ~i_ioNWE & (i_ioAddress == STAT_ADDR);

    // Only the first clock of a held strobe acts.
    assign rd_data_pulse = rd_data & ~rd_data_q;
    assign wr_data_pulse = wr_data & ~wr_data_q;
    assign wr_stat_pulse = wr_stat & ~wr_stat_q;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       fifo_empty, fifo_full, push, tx_pop;

    assign fifo_empty = (count_q == 3'd0);
    assign fifo_full  = (count_q == 3'd4);
    // A full FIFO drops the write even if the transmitter pops this cycle.
    assign push       = wr_data_pulse & ~fifo_full;

    // NOTE: every variable assigned in an always_comb gets a default at the
    // top of the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push)   wr_ptr_d = wr_ptr_q + 2'd1;
        if (tx_pop) rd_ptr_d = rd_ptr_q + 2'd1;
        case ({push, tx_pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: the FIFO storage has no reset; the pointers and count define which
    // entries are valid, so clearing the array would only cost reset routing.
    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wr_ptr_q] <= i_bus;
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    uart_state_e tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = fifo_mem[rd_ptr_q];
                    tx_cnt_d   = '0;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    // Chain straight into the next start bit: no idle gap.
                    if (!fifo_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = fifo_mem[rd_ptr_q];
                        tx_state_d = ST_START;
                    end else begin
                        tx_state_d = ST_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    assign o_tx = (tx_state_q == ST_START) ? 1'b0 :
                  (tx_state_q == ST_DATA)  ? tx_shift_q[0] : 1'b1;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    uart_state_e rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_done, rx_ferr;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                // Recheck at the start-bit centre; a high line was a glitch.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_IDLE;
                    rx_done    = rx_sync_q;
                    rx_ferr    = ~rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Holding register and status flags
    // ------------------------------------------------------------------
    logic [7:0] hold_q, hold_d;
    logic       rx_valid_q, rx_valid_d;
    logic       overrun_q, overrun_d;
    logic       frame_err_q, frame_err_d;
    logic       tx_idle, tx_not_full;
    logic [7:0] status;

    always_comb begin
        hold_d     = rx_done ? rx_shift_q : hold_q;
        // A new byte wins over a same-cycle data read clear.
        rx_valid_d = rx_done | (rx_valid_q & ~rd_data_pulse);
        // Sticky flags: a set in the same cycle as a clear leaves them set.
        overrun_d   = (rx_done & rx_valid_q & ~rd_data_pulse) |
                      (overrun_q & ~(wr_stat_pulse & i_bus[2]));
        frame_err_d = rx_ferr | (frame_err_q & ~(wr_stat_pulse & i_bus[3]));
    end

    assign tx_not_full = ~fifo_full;
    assign tx_idle     = fifo_empty & (tx_state_q == ST_IDLE);
    assign status      = {3'b000, frame_err_q, overrun_q, rx_valid_q, tx_idle, tx_not_full};

    assign o_busEnable = rd_data | rd_stat;
    assign o_bus       = rd_data ? hold_q : (rd_stat ? status : 8'h00);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_data_q   <= 1'b0;
            wr_data_q   <= 1'b0;
            wr_stat_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tx_state_q  <= ST_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= ST_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            hold_q      <= 8'h00;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rd_data_q   <= rd_data;
            wr_data_q   <= wr_data;
            wr_stat_q   <= wr_stat;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            rx_meta_q   <= i_rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            hold_q      <= hold_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_io_uart.sv
// -----------------------------------------------------------------------------
// tb_io_uart -- self-checking bench for io_uart (CLKS_PER_BIT = 16).
// Transmitted bytes are queued as expected when written and compared when the
// serial monitor decodes a frame; received bytes are driven serially and
// checked through bus reads of the data and status registers.
// -----------------------------------------------------------------------------
module tb_io_uart;

    localparam int         CPB  = 16;
    localparam logic [7:0] DATA = 8'h01;
    localparam logic [7:0] STAT = 8'h02;

    logic       clk;
    logic       rst;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_en;
    logic       io_sel;
    logic [7:0] io_addr;
    logic       io_noe;
    logic       io_nwe;
    logic       rx;
    logic       tx;

    io_uart #(
        .CLKS_PER_BIT(CPB),
        .DATA_ADDR   (DATA),
        .STAT_ADDR   (STAT)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_bus      (bus_in),
        .o_bus      (bus_out),
        .o_busEnable(bus_en),
        .i_ioSelect (io_sel),
        .i_ioAddress(io_addr),
        .i_ioNOE    (io_noe),
        .i_ioNWE    (io_nwe),
        .i_rx       (rx),
        .o_tx       (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rst_cnt = 0;

    logic [7:0] tx_exp[$];
    int         start_q[$];

    always @(posedge clk) cyc++;
    always @(posedge rst) rst_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe held low for 'hold' rising edges, then released.
    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data, input int hold);
        @(negedge clk);
        io_sel  = 1'b1;
        io_addr = addr;
        bus_in  = data;
        io_nwe  = 1'b0;
        repeat (hold) @(negedge clk);
        io_sel = 1'b0;
        io_nwe = 1'b1;
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [7:0] data, output logic en);
        @(negedge clk);
        io_sel  = 1'b1;
        io_addr = addr;
        io_noe  = 1'b0;
        #1;
        data = bus_out;
        en   = bus_en;
        @(negedge clk);
        io_sel = 1'b0;
        io_noe = 1'b1;
    endtask

    task automatic read_check(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] d;
        logic       en;
        bus_read(addr, d, en);
        check(tag, {23'd0, en, d}, {23'd0, 1'b1, exp});
    endtask

    task automatic send_byte(input logic [7:0] data, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_tx_drain(input int budget);
        for (int i = 0; i < budget && tx_exp.size() != 0; i++) @(negedge clk);
        check("tx_drain", tx_exp.size(), 0);
    endtask

    // Serial monitor: decodes frames at bit centres; frames cut by reset are discarded.
    initial begin
        logic       prev;
        logic       s0;
        logic       s1;
        logic [7:0] b;
        int         rc;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !tx && !rst) begin
                rc = rst_cnt;
                start_q.push_back(cyc);
                repeat (CPB / 2) @(negedge clk);
                s0 = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                s1 = tx;
                if (rc == rst_cnt) begin
                    check("tx_start_bit", s0, 1'b0);
                    check("tx_stop_bit", s1, 1'b1);
                    check("tx_frame_expected", tx_exp.size() != 0, 1);
                    if (tx_exp.size() != 0) check("tx_byte", b, tx_exp.pop_front());
                end
                prev = 1'b1;
            end else begin
                prev = tx;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       en;

        rst     = 1'b1;
        io_sel  = 1'b0;
        io_addr = 8'h00;
        io_noe  = 1'b1;
        io_nwe  = 1'b1;
        bus_in  = 8'h00;
        rx      = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_bus_en", bus_en, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Reset state and decode boundaries
        read_check("st_after_reset", STAT, 8'h03);
        read_check("hold_after_reset", DATA, 8'h00);
        bus_read(8'h7F, d, en);
        check("other_addr", {23'd0, en, d}, 32'd0);

        // Single frame 0xA5
        bus_write(DATA, 8'hA5, 1);
        tx_exp.push_back(8'hA5);
        read_check("st_tx_busy", STAT, 8'h01);
        wait_tx_drain(400);
        repeat (12) @(negedge clk);
        read_check("st_tx_done", STAT, 8'h03);

        // Burst: 5 writes while idle all accepted, then 6 rapid writes into an
        // empty FIFO behind an active frame: 4 kept, 2 dropped.
        start_q.delete();
        for (int i = 0; i < 5; i++) begin
            bus_write(DATA, 8'h10 + 8'(i), 1);
            tx_exp.push_back(8'h10 + 8'(i));
        end
        repeat (650) @(negedge clk);
        read_check("st_last_frame", STAT, 8'h01);
        for (int i = 0; i < 6; i++) begin
            bus_write(DATA, 8'h20 + 8'(i), 1);
            if (i < 4) tx_exp.push_back(8'h20 + 8'(i));
        end
        read_check("st_fifo_full", STAT, 8'h00);
        wait_tx_drain(2000);
        repeat (12) @(negedge clk);
        check("burst_frames", start_q.size(), 9);
        for (int i = 1; i < start_q.size(); i++)
            check("frame_spacing", start_q[i] - start_q[i-1], 10 * CPB);
        read_check("st_burst_done", STAT, 8'h03);

        // Receive 0x3C
        send_byte(8'h3C, 1'b1);
        read_check("st_rx_valid", STAT, 8'h07);
        read_check("rx_3c", DATA, 8'h3C);
        read_check("st_rx_read", STAT, 8'h03);

        // Overrun: two bytes without reading
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        read_check("st_overrun", STAT, 8'h0F);
        bus_write(STAT, 8'h04, 1);
        read_check("st_ovr_clr", STAT, 8'h07);
        read_check("rx_second", DATA, 8'h22);
        read_check("st_after_ovr", STAT, 8'h03);

        // Frame error with a valid byte pending
        send_byte(8'h55, 1'b1);
        send_byte(8'h99, 1'b0);
        read_check("st_frame_err", STAT, 8'h17);
        read_check("rx_kept", DATA, 8'h55);
        read_check("st_ferr_only", STAT, 8'h13);
        bus_write(STAT, 8'h08, 1);
        read_check("st_ferr_clr", STAT, 8'h03);

        // 4-cycle glitch: no reception
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        read_check("st_glitch", STAT, 8'h03);
        read_check("hold_after_glitch", DATA, 8'h55);

        // Reset mid-frame
        bus_write(DATA, 8'h5A, 1);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        tx_exp.delete();
        repeat (2) @(negedge clk);
        check("tx_in_reset", tx, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("tx_after_reset", tx, 1'b1);
        read_check("st_after_abort", STAT, 8'h03);
        read_check("hold_after_abort", DATA, 8'h00);
        repeat (200) @(negedge clk);

        // Write strobe held 5 cycles queues exactly one byte
        bus_write(DATA, 8'hC3, 5);
        tx_exp.push_back(8'hC3);
        wait_tx_drain(400);
        repeat (12) @(negedge clk);
        read_check("st_one_write", STAT, 8'h03);

        repeat (20) @(negedge clk);
        check("tx_pending", tx_exp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/io_uart.md
IO_UART -- requirements
Module: io_uart

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 4..65535.
REQ-002 Parameter DATA_ADDR, default 8'h01, IO address of the data register.
REQ-003 Parameter STAT_ADDR, default 8'h02, IO address of the status register.
REQ-004 i_clk  in  1  system clock; all state updates on its rising edge.
REQ-005 i_rst  in  1  asynchronous, active-high reset.
REQ-006 i_bus  in  8  CPU data bus, write data.
REQ-007 o_bus  out  8  read data; 8'h00 when o_busEnable is low.
REQ-008 o_busEnable  out  1  high while this block drives the bus.
REQ-009 i_ioSelect  in  1  IO space selected.
REQ-010 i_ioAddress  in  8  IO register address.
REQ-011 i_ioNOE  in  1  active-low read strobe.
REQ-012 i_ioNWE  in  1  active-low write strobe.
REQ-013 i_rx  in  1  asynchronous serial input, idle high.
REQ-014 o_tx  out  1  serial output, idle high.

Function
REQ-015 Read access SHALL be i_ioSelect & ~i_ioNOE & address match; write access SHALL be i_ioSelect & ~i_ioNWE & address match.
REQ-016 o_busEnable SHALL be combinational: high during any read access to DATA_ADDR or STAT_ADDR, otherwise low.
REQ-017 Data read SHALL return the RX holding register; status read SHALL return {3'b0, frame_err, overrun, rx_valid, tx_idle, tx_not_full}.
REQ-018 Writes SHALL be edge-qualified: only the first clock of a continuous write access acts; a strobe held N cycles performs one write.
REQ-019 Reads SHALL likewise be edge-qualified: on the first clock of a data read access, rx_valid SHALL clear; the holding register keeps its value.
REQ-020 A data write SHALL push i_bus into a 4-entry TX FIFO; a write while full SHALL be dropped with FIFO contents unchanged.
REQ-021 A status write SHALL clear overrun where i_bus[2]=1 and frame_err where i_bus[3]=1; other bits are ignored.
REQ-022 tx_not_full SHALL be high when the FIFO holds fewer than 4 entries; tx_idle SHALL be high when the FIFO is empty and the transmitter is in IDLE.
REQ-023 TX states IDLE, START, DATA, STOP; IDLE->START when FIFO non-empty, popping the head entry in the same clock.
REQ-024 o_tx SHALL be 0 in START, bit[i] in DATA (LSB first, i=0..7), 1 in STOP and IDLE; each START/DATA/STOP bit lasts exactly CLKS_PER_BIT cycles.
REQ-025 STOP->START directly if the FIFO is non-empty at the end of the stop bit, else STOP->IDLE; back-to-back frames SHALL have no idle gap.
REQ-026 Simultaneous push and pop SHALL both take effect; a push while full SHALL be dropped even if a pop occurs in the same cycle.
REQ-027 i_rx SHALL pass a 2-flop synchronizer before use.
REQ-028 RX states IDLE, START, DATA, STOP; IDLE->START on a synchronized 1->0 transition.
REQ-029 START SHALL resample at CLKS_PER_BIT/2 cycles; if high, return to IDLE (glitch), else enter DATA.
REQ-030 DATA SHALL sample 8 bits at CLKS_PER_BIT spacing from the start-bit centre, LSB first; STOP samples once more.
REQ-031 At the stop sample: if low, set frame_err, discard the byte, and enter IDLE; if high, load the holding register and set rx_valid; if rx_valid was already set and not cleared in that cycle, also set overrun (new byte overwrites).
REQ-032 A data-read clear and a new-byte set of rx_valid in the same cycle SHALL leave rx_valid=1 without setting overrun.
REQ-033 Sticky-flag clear and set in the same cycle SHALL leave the flag set.

Reset
REQ-034 While i_rst is high: o_tx=1, both FSMs IDLE, FIFO empty, holding register 8'h00, rx_valid/overrun/frame_err=0, edge detectors cleared, synchronizer flops=1.
REQ-035 Reset mid-frame SHALL abort immediately; o_tx is high on the first clock after release, and any partially received byte is discarded.
REQ-036 Status read after reset SHALL return 8'h03.

Verification (CLKS_PER_BIT=16)
REQ-037 Write 8'hA5 to DATA_ADDR -> o_tx low 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, high 16; tx_idle returns to 1.
REQ-038 Write 5 bytes back-to-back while idle -> first byte starts, 4 fit in FIFO, none dropped; then 6 rapid writes -> exactly 4 queued, rest dropped; frames contiguous.
REQ-039 Drive 8'h3C serially -> status 8'h07, data read returns 8'h3C, then status 8'h03.
REQ-040 Receive two bytes without reading -> overrun=1, data=second byte; status write 8'h04 clears overrun.
REQ-041 Serial frame with stop bit low -> frame_err=1, rx_valid unchanged; 4-cycle low glitch on i_rx -> no reception.
REQ-042 Assert i_rst mid-TX-frame -> o_tx=1, status 8'h03 after release; write strobe held 5 cycles -> exactly one byte queued.
